// File: rtl/btn_pkg.sv
// Shared types and default constants for the button debounce / one-shot block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int LONG_CYCLES_DEF     = 64;

  // The accepted (debounced) level is high for the whole pressed episode,
  // including the release-confirmation window.
  function automatic logic is_pressed(input btn_state_t s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_oneshot.sv
// Button debouncer with a one-cycle press pulse and optional long-press pulse.
// Long-press counting is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_oneshot
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic iBtnRaw,
  output logic oBtnLevel,
  output logic oPressPulse,
  output logic oLongPulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 2..2^20");
  end
  if (LONG_CYCLES < 2 || LONG_CYCLES > (1 << 24)) begin : g_bad_long
    $error("LONG_CYCLES out of range 2..2^24");
  end

  btn_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          btn_s;
  logic          press_evt;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (iBtnRaw),
    .q   (btn_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      oBtnLevel   <= 1'b0;
      oPressPulse <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      oBtnLevel   <= is_pressed(state_nx);
      oPressPulse <= press_evt;
    end
  end

  // One counter serves both confirmation windows; it stops at CNT_LAST.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    press_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = PRESS_CHK;
          cnt_nx   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx  = HELD;
          press_evt = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nx = RELEASE_CHK;
          cnt_nx   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;
  logic          long_q;

  // Saturating at HOLD_MAX gives one long pulse per press; release bounces
  // keep counting because they stay in the pressed episode.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_evt) begin
        hold_cnt <= '0;
      end else if (is_pressed(state) && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
        long_q   <= (hold_cnt == HOLD_MAX - HW'(1));
      end
    end
  end

  assign oLongPulse = long_q;
`else
  assign oLongPulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Randomized + directed bench for btn_debounce_oneshot against a run-length debounce model.
module tb_btn_debounce_oneshot;
  import btn_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_DEF;
  localparam int L = LONG_CYCLES_DEF;
`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_ON = 1;
`else
  localparam int LONG_ON = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic iBtnRaw;
  logic oBtnLevel, oPressPulse, oLongPulse;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic chk_en;

  btn_debounce_oneshot #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .iBtnRaw     (iBtnRaw),
    .oBtnLevel   (oBtnLevel),
    .oPressPulse (oPressPulse),
    .oLongPulse  (oLongPulse)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: the level flips once the synchronized input has disagreed with it
  // for D+1 consecutive samples; the long pulse fires after L edges pressed.
  logic [1:0] m_sh;
  logic       m_level, m_press, m_long;
  int         m_run, m_hold;
  logic       bs, n_level, n_press, n_long;
  int         n_run, n_hold;

  always_comb begin
    bs      = m_sh[1];
    n_level = m_level;
    n_run   = 0;
    n_hold  = m_hold;
    n_press = 1'b0;
    n_long  = 1'b0;
    if (LONG_ON == 1 && m_level && m_hold < L) begin
      n_hold = m_hold + 1;
      n_long = (n_hold == L);
    end
    if (bs != m_level) begin
      n_run = m_run + 1;
      if (n_run == D + 1) begin
        n_level = bs;
        n_run   = 0;
        if (bs) begin
          n_press = 1'b1;
          n_hold  = 0;
        end
      end
    end
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_sh <= 2'b00; m_level <= 1'b0; m_press <= 1'b0; m_long <= 1'b0;
      m_run <= 0; m_hold <= 0;
    end else begin
      m_sh <= {m_sh[0], iBtnRaw};
      m_level <= n_level; m_press <= n_press; m_long <= n_long;
      m_run <= n_run; m_hold <= n_hold;
    end
  end

  // Event trackers used by the directed latency checks.
  int   press_cnt = 0, long_cnt = 0, press_at = 0, long_at = 0, rise_at = 0, fall_at = 0;
  logic lvl_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RESET && chk_en) begin
      chk("sb_level", {31'd0, oBtnLevel}, {31'd0, m_level});
      chk("sb_press", {31'd0, oPressPulse}, {31'd0, m_press});
      chk("sb_long", {31'd0, oLongPulse}, {31'd0, m_long});
    end
    if (oPressPulse) begin press_cnt <= press_cnt + 1; press_at <= cyc; end
    if (oLongPulse) begin long_cnt <= long_cnt + 1; long_at <= cyc; end
    if (oBtnLevel && !lvl_prev) rise_at <= cyc;
    if (!oBtnLevel && lvl_prev) fall_at <= cyc;
    lvl_prev <= oBtnLevel;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_level"}, {31'd0, oBtnLevel}, 32'd0);
    chk({tag, "_press"}, {31'd0, oPressPulse}, 32'd0);
    chk({tag, "_long"}, {31'd0, oLongPulse}, 32'd0);
  endtask

  int p0, l0, start;

  initial begin
    RESET = 1'b1; iBtnRaw = 1'b0; chk_en = 1'b0;
    @(negedge CLK);
    chk_outs_zero("rst");
    cyc_wait(2);
    RESET = 1'b0; chk_en = 1'b1;
    cyc_wait(30);

    // Clean press, then clean release.
    p0 = press_cnt; start = cyc; iBtnRaw = 1'b1;
    cyc_wait(100); #1;
    chk("clean_cnt", press_cnt - p0, 1);
    chk("clean_press_edge", press_at - start - 1, D + 2);
    chk("clean_level_edge", rise_at - start - 1, D + 2);
    start = cyc; iBtnRaw = 1'b0;
    cyc_wait(40); #1;
    chk("clean_fall_edge", fall_at - start - 1, D + 2);

    // Press bounce: short burst must be rejected.
    p0 = press_cnt;
    iBtnRaw = 1'b1; cyc_wait(10);
    iBtnRaw = 1'b0; cyc_wait(3);
    #1; chk("bounce_early", press_cnt - p0, 0);
    @(negedge CLK);
    start = cyc; iBtnRaw = 1'b1; cyc_wait(40); #1;
    chk("bounce_cnt", press_cnt - p0, 1);
    chk("bounce_edge", press_at - start - 1, D + 2);

    // Release bounce while held.
    iBtnRaw = 1'b0; cyc_wait(5);
    iBtnRaw = 1'b1; cyc_wait(5);
    start = cyc; iBtnRaw = 1'b0; cyc_wait(30); #1;
    chk("rel_bounce_cnt", press_cnt - p0, 1);
    chk("rel_bounce_fall", fall_at - start - 1, D + 2);

    // Long hold.
    @(negedge CLK);
    p0 = press_cnt; l0 = long_cnt; start = cyc; iBtnRaw = 1'b1;
    cyc_wait(200); #1;
    chk("long_press_cnt", press_cnt - p0, 1);
    chk("long_cnt", long_cnt - l0, LONG_ON);
`ifdef BTN_LONG_PRESS_EN
    chk("long_edge", long_at - start - 1, D + 2 + L);
`endif
    @(negedge CLK);
    iBtnRaw = 1'b0; cyc_wait(40);

    // Reset while the press counter is at 8.
    p0 = press_cnt; iBtnRaw = 1'b1;
    cyc_wait(11);
    #2 RESET = 1'b1;
    #1 chk_outs_zero("rst_mid");
    cyc_wait(2);
    RESET = 1'b0; start = cyc;
    cyc_wait(30); #1;
    chk("rst_mid_cnt", press_cnt - p0, 1);
    chk("rst_mid_edge", press_at - start - 1, D + 2);
    @(negedge CLK);

    // Random segments, occasionally long holds and async resets.
    for (int s = 0; s < 80; s++) begin
      int len;
      iBtnRaw = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(150, 220))
                                          : int'($urandom_range(1, 30));
      if ($urandom_range(0, 15) == 0) begin
        #2 RESET = 1'b1;
        #1 chk_outs_zero("rnd_rst");
        @(negedge CLK);
        RESET = 1'b0;
      end
      cyc_wait(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
